// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 constants, sequencer states and byte-level helpers
package aes_pkg;

    localparam int NR    = 10;
    localparam int BLK_W = 128;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEXP,
        S_KDONE,
        S_RD,
        S_RD_WAIT,
        S_ROUND,
        S_WR,
        S_CDONE
    } seq_state_t;

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] val;
        case (idx)
            4'd1:    val = 8'h01;
            4'd2:    val = 8'h02;
            4'd3:    val = 8'h04;
            4'd4:    val = 8'h08;
            4'd5:    val = 8'h10;
            4'd6:    val = 8'h20;
            4'd7:    val = 8'h40;
            4'd8:    val = 8'h80;
            4'd9:    val = 8'h1b;
            4'd10:   val = 8'h36;
            default: val = 8'h00;
        endcase
        return val;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (group order 255), then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        inv  = gf_mul(gf_mul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// rtl/aes_key_step.sv - derives the next AES-128 round key from the previous one
module aes_key_step
    import aes_pkg::*;
(
    input  logic [BLK_W-1:0] prev_key,
    input  logic [7:0]       rcon_byte,
    output logic [BLK_W-1:0] next_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, sub, t;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = prev_key;
    assign rot = {w3[23:0], w3[31:24]};
    assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    assign t   = sub ^ {rcon_byte, 24'h000000};

    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - key-schedule builder and round sequencer between controller, SRAM and round unit
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_en,
    input  logic [BLK_W-1:0]  key,
    input  logic              con_en,
    input  logic              en_or_de,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [ADDR_W-1:0] loc,
    output logic              key_d,
    output logic              en_d,
    output logic              de_d,
    output logic              sram_re,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [BLK_W-1:0]  sram_wdata,
    input  logic [BLK_W-1:0]  sram_rdata,
    output logic              rnd_go,
    output logic              rnd_inv,
    output logic              rnd_last,
    output logic [BLK_W-1:0]  rnd_state,
    output logic [BLK_W-1:0]  rnd_key,
    input  logic              rnd_ack,
    input  logic [BLK_W-1:0]  rnd_result
);

    localparam logic [3:0] NR4 = 4'(NR);

    seq_state_t        state, state_nxt, cur_state;
    logic [BLK_W-1:0]  rk [0:NR];
    logic [BLK_W-1:0]  kexp_prev;
    logic [BLK_W-1:0]  step_key;
    logic [BLK_W-1:0]  st;
    logic [3:0]        cnt;
    logic [3:0]        r;
    logic [3:0]        rk_idx;
    logic              keys_valid;
    logic              mode_dec;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;

    aes_key_step u_key_step (
        .prev_key  (kexp_prev),
        .rcon_byte (rcon(cnt)),
        .next_key  (step_key)
    );

    // Reset forces the idle decode so every output drops in the same cycle rst is seen.
    assign cur_state = rst ? S_IDLE : state;
    assign rk_idx    = mode_dec ? (NR4 - r) : r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            keys_valid <= 1'b0;
            cnt        <= 4'd0;
            r          <= 4'd0;
            mode_dec   <= 1'b0;
            src_addr   <= '0;
            dst_addr   <= '0;
            st         <= '0;
            kexp_prev  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (key_en) begin
                        kexp_prev  <= key;
                        cnt        <= 4'd1;
                        keys_valid <= 1'b0;
                    end else if (con_en && keys_valid) begin
                        src_addr <= s_addr;
                        dst_addr <= loc;
                        mode_dec <= en_or_de;
                    end
                end
                S_KEXP: begin
                    kexp_prev <= step_key;
                    cnt       <= cnt + 4'd1;
                    if (cnt == NR4) keys_valid <= 1'b1;
                end
                S_RD_WAIT: begin
                    st <= sram_rdata ^ (mode_dec ? rk[NR] : rk[0]);
                    r  <= 4'd1;
                end
                S_ROUND: begin
                    if (rnd_ack) begin
                        st <= rnd_result;
                        r  <= r + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Key file holds no reset: contents only matter once keys_valid is set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_IDLE && key_en) rk[0] <= key;
            else if (state == S_KEXP)      rk[cnt] <= step_key;
        end
    end

    always_comb begin
        state_nxt  = state;
        key_d      = 1'b0;
        en_d       = 1'b0;
        de_d       = 1'b0;
        sram_re    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        rnd_go     = 1'b0;
        rnd_inv    = 1'b0;
        rnd_last   = 1'b0;
        rnd_state  = '0;
        rnd_key    = '0;
        case (cur_state)
            S_IDLE: begin
                if (key_en)                     state_nxt = S_KEXP;
                else if (con_en && keys_valid)  state_nxt = S_RD;
            end
            S_KEXP: begin
                if (cnt == NR4) state_nxt = S_KDONE;
            end
            S_KDONE: begin
                key_d = 1'b1;
                if (!key_en) state_nxt = S_IDLE;
            end
            S_RD: begin
                sram_re   = 1'b1;
                sram_addr = src_addr;
                state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                state_nxt = S_ROUND;
            end
            S_ROUND: begin
                rnd_go    = 1'b1;
                rnd_inv   = mode_dec;
                rnd_last  = (r == NR4);
                rnd_state = st;
                rnd_key   = rk[rk_idx];
                if (rnd_ack && r == NR4) state_nxt = S_WR;
            end
            S_WR: begin
                sram_we    = 1'b1;
                sram_addr  = dst_addr;
                sram_wdata = st;
                state_nxt  = S_CDONE;
            end
            S_CDONE: begin
                en_d = !mode_dec;
                de_d = mode_dec;
                if (!con_en) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - directed vector bench with SRAM and round-unit models
module tb_aes_round_sequencer;

    localparam int W  = 128;
    localparam int AW = 8;
    localparam logic [W-1:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [W-1:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [W-1:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [W-1:0] RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    typedef struct {
        logic          dec;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        int            dly;
        logic [W-1:0]  exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst, key_en, con_en, en_or_de;
    logic [W-1:0]  key;
    logic [AW-1:0] s_addr, loc;
    logic          key_d, en_d, de_d, sram_re, sram_we;
    logic [AW-1:0] sram_addr;
    logic [W-1:0]  sram_wdata, sram_rdata;
    logic          rnd_go, rnd_inv, rnd_last, rnd_ack;
    logic [W-1:0]  rnd_state, rnd_key, rnd_result;

    always #5 clk = ~clk;

    aes_round_sequencer #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .key_en(key_en), .key(key), .con_en(con_en),
        .en_or_de(en_or_de), .s_addr(s_addr), .loc(loc),
        .key_d(key_d), .en_d(en_d), .de_d(de_d),
        .sram_re(sram_re), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .rnd_go(rnd_go), .rnd_inv(rnd_inv), .rnd_last(rnd_last),
        .rnd_state(rnd_state), .rnd_key(rnd_key),
        .rnd_ack(rnd_ack), .rnd_result(rnd_result)
    );

    int n_vec = 0;
    int n_fail = 0;

    logic [7:0]   sb [256];
    logic [7:0]   isb [256];
    logic [W-1:0] rk_m [11];
    logic [W-1:0] mem [256];

    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [W-1:0]  bd_data = '0;
    logic          cur_dec = 1'b0;
    int            max_dly = 0;

    int cyc = 0, t_rd = 0, t_wr = 0, n_re = 0, n_we = 0;
    int ack_idx = 0, key_bad = 0, stab_bad = 0, extra_waits = 0;
    int wait_cnt = 0, wait_tgt = 0;
    logic         pend = 1'b0;
    logic [W-1:0] pend_state = '0, pend_key = '0, last_key_seen = '0;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        while (y != 8'h00) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        logic [7:0] s;
        logic [7:0] c = 8'h63;
        for (int i = 0; i < 8; i++)
            s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ c[i];
        return s;
    endfunction

    function automatic logic [W-1:0] round_model(input logic [W-1:0] s, input logic [W-1:0] k,
                                                 input logic inv, input logic last);
        logic [7:0] a [16];
        logic [7:0] b [16];
        logic [7:0] col [4];
        logic [7:0] cf [4];
        logic [7:0] acc;
        logic [W-1:0] o;
        for (int i = 0; i < 16; i++) a[i] = s[W-1-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[4*c+r] = inv ? isb[a[4*((c - r + 4) % 4) + r]] : sb[a[4*((c + r) % 4) + r]];
        if (inv) for (int i = 0; i < 16; i++) b[i] = b[i] ^ k[W-1-8*i -: 8];
        if (inv) begin cf[0] = 8'd14; cf[1] = 8'd11; cf[2] = 8'd13; cf[3] = 8'd9; end
        else     begin cf[0] = 8'd2;  cf[1] = 8'd3;  cf[2] = 8'd1;  cf[3] = 8'd1; end
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) col[r] = b[4*c+r];
                for (int r = 0; r < 4; r++) begin
                    acc = 8'h00;
                    for (int j = 0; j < 4; j++) acc = acc ^ gmul(cf[(j - r + 4) % 4], col[j]);
                    b[4*c+r] = acc;
                end
            end
        end
        if (!inv) for (int i = 0; i < 16; i++) b[i] = b[i] ^ k[W-1-8*i -: 8];
        for (int i = 0; i < 16; i++) o[W-1-8*i -: 8] = b[i];
        return o;
    endfunction

    task automatic build_keys(input logic [W-1:0] k);
        logic [7:0]  rc;
        logic [31:0] w [4];
        logic [31:0] t;
        rc = 8'h01;
        rk_m[0] = k;
        for (int i = 1; i <= 10; i++) begin
            for (int j = 0; j < 4; j++) w[j] = rk_m[i-1][W-1-32*j -: 32];
            t = {sb[w[3][23:16]], sb[w[3][15:8]], sb[w[3][7:0]], sb[w[3][31:24]]} ^ {rc, 24'h0};
            w[0] = w[0] ^ t;
            w[1] = w[1] ^ w[0];
            w[2] = w[2] ^ w[1];
            w[3] = w[3] ^ w[2];
            rk_m[i] = {w[0], w[1], w[2], w[3]};
            rc = xt(rc);
        end
    endtask

    assign rnd_result = round_model(rnd_state, rnd_key, rnd_inv, rnd_last);
    assign rnd_ack    = rnd_go && (wait_cnt >= wait_tgt);

    // SRAM, round-unit delay model and bus monitor
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bd_we) mem[bd_addr] <= bd_data;
        if (sram_re) begin
            sram_rdata <= mem[sram_addr];
            t_rd       <= cyc;
            n_re       <= n_re + 1;
            ack_idx    <= 0;
        end
        if (sram_we) begin
            mem[sram_addr] <= sram_wdata;
            t_wr <= cyc;
            n_we <= n_we + 1;
        end
        if (rnd_go && rnd_ack) begin
            wait_cnt <= 0;
            wait_tgt <= (max_dly == 0) ? 0 : int'($urandom_range(max_dly, 0));
            if (ack_idx > 9 ||
                rnd_key !== (cur_dec ? rk_m[9 - ack_idx] : rk_m[ack_idx + 1]) ||
                rnd_inv !== cur_dec || rnd_last !== (ack_idx == 9))
                key_bad <= key_bad + 1;
            if (rnd_last) last_key_seen <= rnd_key;
            ack_idx <= ack_idx + 1;
        end else if (rnd_go) begin
            wait_cnt    <= wait_cnt + 1;
            extra_waits <= extra_waits + 1;
        end
        if (pend && !rst && (!rnd_go || rnd_state !== pend_state || rnd_key !== pend_key))
            stab_bad <= stab_bad + 1;
        pend       <= rnd_go && !rnd_ack && !rst;
        pend_state <= rnd_state;
        pend_key   <= rnd_key;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_quiet(input string name);
        check({name, "_ctl"}, W'({key_d, en_d, de_d, sram_re, sram_we, rnd_go, rnd_inv, rnd_last}), '0);
        check({name, "_bus"}, W'(|{sram_addr, sram_wdata, rnd_state, rnd_key}), '0);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [W-1:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        tick;
        bd_we   = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int kb0, sb0, ew0, we0, k;
        max_dly = v.dly;
        cur_dec = v.dec;
        kb0 = key_bad; sb0 = stab_bad; ew0 = extra_waits; we0 = n_we;
        en_or_de = v.dec;
        s_addr   = v.src;
        loc      = v.dst;
        con_en   = 1'b1;
        tick;
        en_or_de = ~v.dec;
        s_addr   = 8'hff;
        loc      = 8'hfe;
        k = 0;
        while (!(en_d || de_d) && k < 400) begin
            tick;
            k++;
        end
        check({nm, "_done"}, W'({en_d, de_d}), W'(v.dec ? 2'b01 : 2'b10));
        check({nm, "_result"}, mem[v.dst], v.exp);
        check({nm, "_latency"}, W'(t_wr - t_rd), W'(12 + extra_waits - ew0));
        check({nm, "_round_keys"}, W'(key_bad - kb0), '0);
        check({nm, "_go_stable"}, W'(stab_bad - sb0), '0);
        check({nm, "_one_write"}, W'(n_we - we0), W'(1));
        repeat (3) tick;
        check({nm, "_done_held"}, W'({en_d, de_d}), W'(v.dec ? 2'b01 : 2'b10));
        con_en = 1'b0;
        tick;
        check({nm, "_done_drop"}, W'({en_d, de_d}), '0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt [5];
        logic [7:0] inv;
        int seen, re0, we0, k;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = affine(inv);
        end
        for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);

        vt[0] = '{1'b0, 8'h05, 8'h20, 0, CT};
        vt[1] = '{1'b1, 8'h20, 8'h21, 0, PT};
        vt[2] = '{1'b0, 8'h05, 8'h30, 5, CT};
        vt[3] = '{1'b1, 8'h30, 8'h31, 5, PT};
        vt[4] = '{1'b0, 8'h40, 8'h40, 2, CT};

        rst = 1'b1; key_en = 1'b0; con_en = 1'b0; en_or_de = 1'b0;
        key = '0; s_addr = '0; loc = '0;
        preload(8'h05, PT);
        preload(8'h40, PT);
        preload(8'h50, '0);
        tick;
        check_quiet("reset");
        rst = 1'b0;
        tick;

        // cipher request with no key schedule must be ignored
        re0 = n_re;
        seen = 0;
        con_en = 1'b1;
        repeat (50) begin
            tick;
            if (en_d || de_d || sram_re) seen++;
        end
        check("nokey_no_read", W'(n_re - re0), '0);
        check("nokey_no_done", W'(seen), '0);
        con_en = 1'b0;
        tick;

        build_keys(KEY);
        key    = KEY;
        key_en = 1'b1;
        repeat (10) tick;
        check("key_d_before_11", W'(key_d), '0);
        tick;
        check("key_d_at_11", W'(key_d), W'(1));
        key = ~KEY;
        repeat (3) tick;
        check("key_d_held", W'(key_d), W'(1));
        key_en = 1'b0;
        tick;
        check("key_d_drop", W'(key_d), '0);

        for (int i = 0; i < 5; i++) begin
            run_vec(vt[i], $sformatf("vec%0d", i));
            if (i == 0) check("rk10_on_last_round", last_key_seen, RK10);
        end

        // abort in the middle of round 5
        max_dly = 0; cur_dec = 1'b0;
        we0 = n_we;
        en_or_de = 1'b0; s_addr = 8'h05; loc = 8'h50; con_en = 1'b1;
        k = 0;
        while (!(rnd_go && ack_idx == 4) && k < 100) begin
            tick;
            k++;
        end
        check("abort_reached_r5", W'(ack_idx), W'(4));
        rst = 1'b1;
        con_en = 1'b0;
        tick;
        check_quiet("abort");
        rst = 1'b0;
        repeat (15) tick;
        check("abort_no_write", W'(n_we - we0), '0);
        check("abort_dst_untouched", mem[8'h50], '0);

        // recovery with an early key_en drop during expansion
        key = KEY;
        key_en = 1'b1;
        repeat (3) tick;
        key_en = 1'b0;
        k = 0;
        while (!key_d && k < 30) begin
            tick;
            k++;
        end
        check("rekey_done", W'(key_d), W'(1));
        tick;
        run_vec('{1'b0, 8'h05, 8'h50, 0, CT}, "recover");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
